enemy_laser: RTL and testbench
==============================

Name: enemy_laser

Overview:
Single enemy projectile. It spawns at a firing enemy's gun position, falls one step per frame, and checks collision against the player ship box. On a hit it drives the player's hit_i input with a one-cycle pulse that is aligned to frame_i, so the player's life counter decrements on that same frame. One instance per concurrent enemy shot; the enemy formation logic arbitrates fire_i across instances using ready_o.

Parameters:
color_p, {4'hF,4'h2,4'h2}, laser color {Red,Green,Blue}
width_p, 10'd4, laser width in pixels (even, ≥2)
height_p, 10'd12, laser height in pixels
speed_p, 10'd4, pixels moved down per unpaused frame
player_top_p, 10'd440, top row of the player ship
bottom_border_p, 10'd479, last visible row
cooldown_p, 6'd30, frames spent in COOLDOWN before re-arming

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
frame_i  in  1  one-cycle pulse per display frame
pause_i  in  1  freeze (player shot, resume pending)
fire_i  in  1  request to launch a laser
fire_x_i  in  10  gun x-centre of the firing enemy
fire_y_i  in  10  spawn row (laser top)
player_left_i  in  10  player left edge (player pos_left_o)
player_right_i  in  10  player right edge (player pos_right_o)
player_alive_i  in  1  player alive_o
hit_o  out  1  to player hit_i; one-cycle pulse
active_o  out  1  laser visible
ready_o  out  1  IDLE; able to accept fire_i
laser_left_o  out  10  left edge
laser_right_o  out  10  left + width_p - 1
laser_top_o  out  10  top row
laser_bottom_o  out  10  top + height_p - 1
laser_red_o / laser_green_o / laser_blue_o  out  4 each  from color_p
pres_state_o  out  3  present state, for debug

Behaviour:
- One-hot states: IDLE=3'b001, FALLING=3'b010, COOLDOWN=3'b100. Any other encoding goes to IDLE on the next clock.
- Reset (dominates all inputs): IDLE; left=0, top=0, cooldown counter=0. Outputs hit_o=0, active_o=0, ready_o=1.
- IDLE → FALLING launch condition: fire_i & player_alive_i & ~pause_i. No frame_i is needed.
  - Latch on the clock edge: left = fire_x_i − width_p/2, top = fire_y_i.
  - Clamp: if fire_x_i < width_p/2, left=0. If fire_x_i + width_p/2 > 639, left = 640 − width_p.
- Overlap test (combinational): laser_left ≤ player_right_i AND laser_right ≥ player_left_i AND laser_bottom ≥ player_top_p.
- FALLING, on a frame_i & ~pause_i cycle, priority order:
  1. Overlap: hit_o=1 in that same cycle (combinational from registered state plus inputs). Next state COOLDOWN.
  2. Else if top + height_p + speed_p > bottom_border_p: next state COOLDOWN, hit_o=0.
  3. Else: top += speed_p.
  - Hit takes priority over the bottom-border exit in the same frame.
- FALLING, ~player_alive_i on any cycle: go to IDLE next edge; hit_o=0.
- COOLDOWN entry: counter loads cooldown_p.
  - Each frame_i & ~pause_i: if counter==0, go to IDLE; else decrement.
  - Total COOLDOWN duration is cooldown_p+1 frames.
- pause_i=1: freezes position, state and counter; forces hit_o=0. pause_i has priority over frame_i.
- fire_i outside IDLE is ignored. There is no queueing.
- active_o=1 only in FALLING. ready_o=1 only in IDLE.
- All arithmetic is 10-bit unsigned. Parameter constraints guarantee no overflow.
- hit_o is never high for more than one cycle per launch.

Test Plan:
- Launch and hit: fire_x_i=300, fire_y_i=100, player_left_i=280, player_right_i=320.
  → left 298, right 301, top 100 the cycle after fire_i.
  → top 432 after 83 frames; hit_o pulses for exactly 1 cycle, coincident with the 84th frame_i.
  → next state COOLDOWN.
- Miss: same launch, player_left_i=400, player_right_i=440.
  → top reaches 464 after 91 frames; 92nd frame enters COOLDOWN; hit_o never asserts.
  → ready_o returns 31 frames later.
- Pause: pause_i held for 10 frame_i pulses while top=200.
  → top stays 200 and hit_o stays 0.
  → after release, top=204 on the next frame.
- Clamp and ignore:
  → fire_x_i=1 gives left=0.
  → fire_x_i=639 gives left=636.
  → a second fire_i during FALLING leaves position unchanged.
- Reset and death:
  → reset_i mid-fall gives IDLE, active_o=0, top=0 next cycle.
  → player_alive_i=0 mid-fall gives IDLE next cycle with hit_o=0.

Source files
------------

// File: rtl/enemy_laser.sv
// Single falling enemy projectile: launches from an enemy gun, descends one step
// per frame, and signals a frame-aligned hit pulse when it overlaps the player ship.
module enemy_laser #(
  parameter logic [11:0] color_p         = {4'hF, 4'h2, 4'h2},
  parameter logic [9:0]  width_p         = 10'd4,
  parameter logic [9:0]  height_p        = 10'd12,
  parameter logic [9:0]  speed_p         = 10'd4,
  parameter logic [9:0]  player_top_p    = 10'd440,
  parameter logic [9:0]  bottom_border_p = 10'd479,
  parameter logic [5:0]  cooldown_p      = 6'd30
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       pause_i,
  input  logic       fire_i,
  input  logic [9:0] fire_x_i,
  input  logic [9:0] fire_y_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  input  logic       player_alive_i,
  output logic       hit_o,
  output logic       active_o,
  output logic       ready_o,
  output logic [9:0] laser_left_o,
  output logic [9:0] laser_right_o,
  output logic [9:0] laser_top_o,
  output logic [9:0] laser_bottom_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [2:0] pres_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    FALLING  = 3'b010,
    COOLDOWN = 3'b100
  } state_t;

  localparam logic [9:0] half_w      = width_p >> 1;
  localparam logic [9:0] right_limit = 10'd639;
  localparam logic [9:0] max_left    = 10'd640 - width_p;

  state_t     pres_state, next_state;
  logic [9:0] left, top, right, bottom, spawn_left;
  logic [5:0] cnt;
  logic       step, launch, overlap, bottom_exit;

  assign step        = frame_i & ~pause_i;
  assign launch      = fire_i & player_alive_i & ~pause_i;
  assign right       = left + width_p - 10'd1;
  assign bottom      = top + height_p - 10'd1;
  assign overlap     = (left <= player_right_i) && (right >= player_left_i) &&
                       (bottom >= player_top_p);
  assign bottom_exit = (top + height_p + speed_p) > bottom_border_p;

  // Keep the whole laser on the 640-pixel-wide screen at spawn.
  always_comb begin
    if (fire_x_i < half_w)
      spawn_left = '0;
    else if (fire_x_i + half_w > right_limit)
      spawn_left = max_left;
    else
      spawn_left = fire_x_i - half_w;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pres_state <= IDLE;
    else         pres_state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives next_state and no latch is inferred.
    next_state = pres_state;
    case (pres_state)
      IDLE:     if (launch) next_state = FALLING;
      // Losing the player aborts the shot even while paused.
      FALLING:  if (!player_alive_i)                    next_state = IDLE;
                else if (step && (overlap || bottom_exit)) next_state = COOLDOWN;
      COOLDOWN: if (step && cnt == 6'd0) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    hit_o    = 1'b0;
    active_o = 1'b0;
    ready_o  = 1'b0;
    case (pres_state)
      IDLE:    ready_o = 1'b1;
      FALLING: begin
        active_o = 1'b1;
        hit_o    = step & player_alive_i & overlap & ~reset_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      left <= '0;
      top  <= '0;
      cnt  <= '0;
    end else begin
      case (pres_state)
        IDLE: if (launch) begin
          left <= spawn_left;
          top  <= fire_y_i;
        end
        FALLING: if (player_alive_i && step) begin
          if (overlap || bottom_exit) cnt <= cooldown_p;
          else                        top <= top + speed_p;
        end
        COOLDOWN: if (step && cnt != 6'd0) cnt <= cnt - 6'd1;
        default: ;
      endcase
    end
  end

  assign laser_left_o   = left;
  assign laser_right_o  = right;
  assign laser_top_o    = top;
  assign laser_bottom_o = bottom;
  assign laser_red_o    = color_p[11:8];
  assign laser_green_o  = color_p[7:4];
  assign laser_blue_o   = color_p[3:0];
  assign pres_state_o   = pres_state;

endmodule

// File: tb/tb_enemy_laser.sv
// Scoreboard bench for enemy_laser: expected position/state records and expected
// hit frames are queued by the stimulus and consumed by independent monitors.
module tb_enemy_laser;

  localparam logic [2:0] S_IDLE = 3'b001, S_FALL = 3'b010, S_COOL = 3'b100;

  logic       clk_i, reset_i, frame_i, pause_i, fire_i, player_alive_i;
  logic [9:0] fire_x_i, fire_y_i, player_left_i, player_right_i;
  logic       hit_o, active_o, ready_o;
  logic [9:0] laser_left_o, laser_right_o, laser_top_o, laser_bottom_o;
  logic [3:0] laser_red_o, laser_green_o, laser_blue_o;
  logic [2:0] pres_state_o;

  enemy_laser dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_i(frame_i), .pause_i(pause_i),
    .fire_i(fire_i), .fire_x_i(fire_x_i), .fire_y_i(fire_y_i),
    .player_left_i(player_left_i), .player_right_i(player_right_i),
    .player_alive_i(player_alive_i), .hit_o(hit_o), .active_o(active_o),
    .ready_o(ready_o), .laser_left_o(laser_left_o), .laser_right_o(laser_right_o),
    .laser_top_o(laser_top_o), .laser_bottom_o(laser_bottom_o),
    .laser_red_o(laser_red_o), .laser_green_o(laser_green_o),
    .laser_blue_o(laser_blue_o), .pres_state_o(pres_state_o)
  );

  typedef struct {
    string      name;
    logic [9:0] left;
    logic [9:0] top;
    logic [2:0] st;
    logic       active;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   hit_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_num = 0;
  exp_t e;
  int   want_frame;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_frame();
    frame_i = 1'b1;
    frame_num++;
    tick();
    frame_i = 1'b0;
    tick();
  endtask

  task automatic do_frames(input int n);
    repeat (n) do_frame();
  endtask

  task automatic launch(input logic [9:0] x, input logic [9:0] y);
    fire_x_i = x;
    fire_y_i = y;
    fire_i   = 1'b1;
    tick();
    fire_i   = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [9:0] l, input logic [9:0] t,
                          input logic [2:0] s);
    exp_t x;
    x.name   = name;
    x.left   = l;
    x.top    = t;
    x.st     = s;
    x.active = (s == S_FALL);
    x.ready  = (s == S_IDLE);
    exp_q.push_back(x);
  endtask

  // Position/state monitor.
  always @(negedge clk_i) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (laser_left_o !== e.left || laser_right_o !== e.left + 10'd3 ||
          laser_top_o !== e.top || laser_bottom_o !== e.top + 10'd11 ||
          pres_state_o !== e.st || active_o !== e.active || ready_o !== e.ready) begin
        errors++;
        $display("FAIL %s: got l=%0d r=%0d t=%0d b=%0d st=%b act=%b rdy=%b, want l=%0d r=%0d t=%0d b=%0d st=%b act=%b rdy=%b",
                 e.name, laser_left_o, laser_right_o, laser_top_o, laser_bottom_o,
                 pres_state_o, active_o, ready_o, e.left, e.left + 10'd3, e.top,
                 e.top + 10'd11, e.st, e.active, e.ready);
      end
    end
  end

  // Hit monitor: every observed hit must match a queued expected frame.
  always @(negedge clk_i) begin
    if (hit_o === 1'b1) begin
      checks++;
      if (hit_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: got hit_o=1 at frame %0d, want hit_o=0", frame_num);
      end else begin
        want_frame = hit_q.pop_front();
        if (want_frame != frame_num || frame_i !== 1'b1) begin
          errors++;
          $display("FAIL hit_frame: got hit at frame %0d (frame_i=%b), want frame %0d (frame_i=1)",
                   frame_num, frame_i, want_frame);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; frame_i = 1'b0; pause_i = 1'b0; fire_i = 1'b0;
    fire_x_i = '0; fire_y_i = '0; player_left_i = '0; player_right_i = '0;
    player_alive_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    push_exp("reset", 10'd0, 10'd0, S_IDLE);
    checks++;
    if ({laser_red_o, laser_green_o, laser_blue_o} !== 12'hF22) begin
      errors++;
      $display("FAIL color: got %h, want f22", {laser_red_o, laser_green_o, laser_blue_o});
    end

    // Launch is blocked while paused or with the player dead.
    pause_i = 1'b1;
    launch(10'd300, 10'd100);
    pause_i = 1'b0;
    push_exp("fire_paused", 10'd0, 10'd0, S_IDLE);
    player_alive_i = 1'b0;
    launch(10'd300, 10'd100);
    player_alive_i = 1'b1;
    push_exp("fire_dead", 10'd0, 10'd0, S_IDLE);

    // Launch and hit.
    player_left_i = 10'd280; player_right_i = 10'd320;
    launch(10'd300, 10'd100);
    push_exp("launch", 10'd298, 10'd100, S_FALL);
    do_frames(83);
    push_exp("pre_hit", 10'd298, 10'd432, S_FALL);
    hit_q.push_back(frame_num + 1);
    do_frame();
    push_exp("after_hit", 10'd298, 10'd432, S_COOL);
    do_frames(30);
    push_exp("hit_cool_30", 10'd298, 10'd432, S_COOL);
    do_frame();
    push_exp("hit_cool_done", 10'd298, 10'd432, S_IDLE);

    // Miss: falls to the bottom border.
    player_left_i = 10'd400; player_right_i = 10'd440;
    launch(10'd300, 10'd100);
    push_exp("miss_launch", 10'd298, 10'd100, S_FALL);
    do_frames(91);
    push_exp("miss_bottom", 10'd298, 10'd464, S_FALL);
    do_frame();
    push_exp("miss_exit", 10'd298, 10'd464, S_COOL);
    do_frames(30);
    push_exp("miss_cool_30", 10'd298, 10'd464, S_COOL);
    do_frame();
    push_exp("miss_ready", 10'd298, 10'd464, S_IDLE);

    // Pause mid-fall, then player death.
    launch(10'd300, 10'd200);
    push_exp("pause_launch", 10'd298, 10'd200, S_FALL);
    pause_i = 1'b1;
    do_frames(10);
    push_exp("paused", 10'd298, 10'd200, S_FALL);
    pause_i = 1'b0;
    do_frame();
    push_exp("resumed", 10'd298, 10'd204, S_FALL);
    player_alive_i = 1'b0;
    tick();
    push_exp("death", 10'd298, 10'd204, S_IDLE);
    player_alive_i = 1'b1;

    // Pause suppresses a pending hit; release delivers it.
    player_left_i = 10'd280; player_right_i = 10'd320;
    launch(10'd300, 10'd432);
    pause_i = 1'b1;
    do_frames(2);
    push_exp("pause_at_hit", 10'd298, 10'd432, S_FALL);
    pause_i = 1'b0;
    hit_q.push_back(frame_num + 1);
    do_frame();
    push_exp("hit_after_pause", 10'd298, 10'd432, S_COOL);
    do_frames(31);
    push_exp("cool_done_2", 10'd298, 10'd432, S_IDLE);

    // Clamp, ignored refire, reset mid-fall.
    player_left_i = 10'd400; player_right_i = 10'd440;
    launch(10'd1, 10'd50);
    push_exp("clamp_left", 10'd0, 10'd50, S_FALL);
    launch(10'd100, 10'd300);
    push_exp("refire_ignored", 10'd0, 10'd50, S_FALL);
    do_frame();
    push_exp("fall_step", 10'd0, 10'd54, S_FALL);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    push_exp("reset_mid_fall", 10'd0, 10'd0, S_IDLE);
    launch(10'd639, 10'd60);
    push_exp("clamp_right", 10'd636, 10'd60, S_FALL);

    tick(); tick();
    checks++;
    if (hit_q.size() != 0) begin
      errors++;
      $display("FAIL missing_hit: got %0d hits outstanding, want 0", hit_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
